// File: rtl/masked_barrett_ctrl.sv
// Streams masked coefficients memory -> reduction unit -> memory; the two shares never meet.
// Optional ABR_BARRETT_RND_GATE_EN: a coefficient is only issued when rnd_valid is high.
module masked_barrett_ctrl #(
  parameter int MASKED_REG_SIZE = 24,
  parameter int ADDR_WIDTH      = 7,
  parameter int RED_LATENCY     = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         zeroize,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        src_base_addr,
  input  logic [ADDR_WIDTH-1:0]        dst_base_addr,
  input  logic [ADDR_WIDTH:0]          num_coeffs,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_rd_addr,
  input  logic [2*MASKED_REG_SIZE-1:0] mem_rd_data,
  output logic [2*MASKED_REG_SIZE-1:0] red_x,
  input  logic [2*MASKED_REG_SIZE-1:0] red_y,
  output logic                         mem_wr_en,
  output logic [ADDR_WIDTH-1:0]        mem_wr_addr,
  output logic [2*MASKED_REG_SIZE-1:0] mem_wr_data,
  output logic                         rnd_req,
  input  logic                         rnd_valid
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                               r_state;
  state_t                               w_state_nxt;
  logic [ADDR_WIDTH-1:0]                r_src;
  logic [ADDR_WIDTH-1:0]                r_dst;
  logic [ADDR_WIDTH:0]                  r_num;
  logic [ADDR_WIDTH:0]                  r_cnt;
  logic [RED_LATENCY:0]                 r_vld;
  logic [RED_LATENCY:0][ADDR_WIDTH-1:0] r_waddr;

  logic                                 w_issue;
  logic                                 w_last_issue;
  logic                                 w_drain_empty;
  logic [ADDR_WIDTH-1:0]                w_wr_addr_nxt;
  logic                                 w_unused_rnd;

`ifdef ABR_BARRETT_RND_GATE_EN
  assign w_issue      = (r_state == S_ISSUE) && rnd_valid;
  assign w_unused_rnd = 1'b0;
`else
  assign w_issue      = (r_state == S_ISSUE);
  assign w_unused_rnd = rnd_valid;
`endif

  assign w_last_issue  = w_issue && ((r_cnt + CNT_ONE) == r_num);
  // Once issuing has stopped, the write at the pipe tail is the last one if nothing trails it.
  assign w_drain_empty = (r_vld[RED_LATENCY-1:0] == '0);
  assign w_wr_addr_nxt = w_issue ? (r_dst + r_cnt[ADDR_WIDTH-1:0]) : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (num_coeffs == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_last_issue) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_wr_en && w_drain_empty) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_num   <= '0;
      r_cnt   <= '0;
      r_vld   <= '0;
      r_waddr <= '0;
    end else if (zeroize) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_num   <= '0;
      r_cnt   <= '0;
      r_vld   <= '0;
      r_waddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && start) begin
        r_src <= src_base_addr;
        r_dst <= dst_base_addr;
        r_num <= num_coeffs;
        r_cnt <= '0;
      end else if (w_issue) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      r_vld   <= {r_vld[RED_LATENCY-1:0], w_issue};
      r_waddr <= {r_waddr[RED_LATENCY-1:0], w_wr_addr_nxt};
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = w_issue ? (r_src + r_cnt[ADDR_WIDTH-1:0]) : '0;
  assign red_x       = r_vld[0] ? mem_rd_data : '0;
  assign rnd_req     = r_vld[0];
  assign mem_wr_en   = r_vld[RED_LATENCY];
  assign mem_wr_addr = r_waddr[RED_LATENCY];
  assign mem_wr_data = mem_wr_en ? red_y : '0;

endmodule
